wb_acum: RTL and testbench

Write-back stage of the 8-bit accumulator pipeline. It sits after the memory stage and consumes that stage's 8-bit result and 3-bit accumulator control, and holds them in the MEM/WB pipeline register. It commits the result into the A/B accumulator file and provides write-through bypassed accumulator values and a zero flag to decode and branch logic.

---
 rtl/wb_acum_pkg.sv | 28 ++
 rtl/wb_acum_if.sv | 29 ++
 rtl/wb_acum_acum_file.sv | 38 +++
 rtl/wb_acum.sv | 63 ++++++
 tb/tb_wb_acum.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_acum_pkg.sv
// Accumulator pipeline definitions shared by the memory and write-back stages.
// Control word layout: bit ACUM_WE is the write enable, [1:0] is the target.
package wb_acum_pkg;

  localparam int ACUM_DATA_W = 8;
  localparam int ACUM_WE     = 2;

  typedef enum logic [1:0] {
    ACUM_A    = 2'b00,
    ACUM_B    = 2'b01,
    ACUM_AB   = 2'b10,
    ACUM_RSVD = 2'b11
  } acum_tgt_e;

  typedef struct packed {
    logic      we;
    acum_tgt_e tgt;
  } acum_ctrl_t;

  function automatic logic tgt_hits_a(acum_tgt_e t);
    return (t == ACUM_A) || (t == ACUM_AB);
  endfunction

  function automatic logic tgt_hits_b(acum_tgt_e t);
    return (t == ACUM_B) || (t == ACUM_AB);
  endfunction

endpackage

// File: rtl/wb_acum_if.sv
// MEM -> WB slot plus the bypassed accumulator view returned to decode/branch.
// master = memory-stage side, slave = write-back stage.
interface wb_acum_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) ();

  logic [DATA_W-1:0] data_to_wb;
  logic [2:0]        control_acum_mem;
  logic              valid_mem;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] acum_a;
  logic [DATA_W-1:0] acum_b;
  logic              zero;
  logic              wb_busy;
  logic [CNT_W-1:0]  retired;

  modport master (
    output data_to_wb, control_acum_mem, valid_mem, stall, flush,
    input  acum_a, acum_b, zero, wb_busy, retired
  );

  modport slave (
    input  data_to_wb, control_acum_mem, valid_mem, stall, flush,
    output acum_a, acum_b, zero, wb_busy, retired
  );

endinterface

// File: rtl/wb_acum_acum_file.sv
// A/B architectural accumulators and the zero flag of the last committed value.
// One write port; a write may hit A, B or both with the same data.
module acum_file
  import wb_acum_pkg::*;
#(
  parameter int DATA_W = ACUM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  acum_tgt_e         tgt,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              zero
);

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      zero_q <= 1'b1;
    end else if (we) begin
      if (tgt_hits_a(tgt)) a_q <= data;
      if (tgt_hits_b(tgt)) b_q <= data;
      zero_q <= (data == '0);
    end
  end

  assign a    = a_q;
  assign b    = b_q;
  assign zero = zero_q;

endmodule

// File: rtl/wb_acum.sv
// Write-back stage: MEM/WB register, commit into the accumulator file, bypass, retire count.
// Slot visible on the bypass 1 edge after capture, architectural 1 edge later; stall freezes all state.
module wb_acum
  import wb_acum_pkg::*;
#(
  parameter int DATA_W = ACUM_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  wb_acum_if.slave wb
);

  logic [DATA_W-1:0] data_q;
  acum_ctrl_t        ctrl_q;
  logic              valid_q;
  logic [CNT_W-1:0]  retired_q;

  logic              pend_wr;
  logic              commit;
  logic [DATA_W-1:0] st_a;
  logic [DATA_W-1:0] st_b;

  // Stall holds the slot; flush only turns the incoming slot into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
    end else if (!wb.stall) begin
      data_q  <= wb.data_to_wb;
      ctrl_q  <= acum_ctrl_t'(wb.control_acum_mem);
      valid_q <= wb.valid_mem & ~wb.flush;
    end
  end

  assign pend_wr = valid_q & ctrl_q.we & (ctrl_q.tgt != ACUM_RSVD);
  assign commit  = pend_wr & ~wb.stall;

  acum_file #(.DATA_W(DATA_W)) u_file (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (commit),
    .tgt  (ctrl_q.tgt),
    .data (data_q),
    .a    (st_a),
    .b    (st_b),
    .zero (wb.zero)
  );

  // A dual-target write counts as one retired instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      retired_q <= '0;
    else if (commit) retired_q <= retired_q + 1'b1;
  end

  // Bypass ignores stall so decode sees the value that will eventually commit.
  assign wb.acum_a  = (pend_wr && tgt_hits_a(ctrl_q.tgt)) ? data_q : st_a;
  assign wb.acum_b  = (pend_wr && tgt_hits_b(ctrl_q.tgt)) ? data_q : st_b;
  assign wb.wb_busy = pend_wr;
  assign wb.retired = retired_q;

endmodule

// File: tb/tb_wb_acum.sv
// Bench for wb_acum: scenario tasks with inline checks plus a commit scoreboard.
module tb_wb_acum;
  import wb_acum_pkg::*;

  typedef struct {
    logic [1:0] tgt;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_acum_if #(.DATA_W(8), .CNT_W(16)) bus ();

  wb_acum #(.DATA_W(8), .CNT_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wb   (bus)
  );

  int         total = 0;
  int         bad = 0;
  exp_t       sb[$];
  logic [15:0] exp_ret = '0;
  logic [7:0]  mod_a = '0;
  logic [7:0]  mod_b = '0;
  logic        mod_z = 1'b1;

  // Every observed commit pops the oldest expected write and checks the file.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && bus.retired !== exp_ret) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_spurious_commit retired=%0d expected=%0d", bus.retired, exp_ret);
        exp_ret = bus.retired;
      end else begin
        e = sb.pop_front();
        exp_ret = exp_ret + 16'd1;
        if (e.tgt == 2'b00 || e.tgt == 2'b10) mod_a = e.data;
        if (e.tgt == 2'b01 || e.tgt == 2'b10) mod_b = e.data;
        mod_z = (e.data == 8'h00);
        if (bus.retired !== exp_ret || dut.u_file.a_q !== mod_a ||
            dut.u_file.b_q !== mod_b || bus.zero !== mod_z) begin
          bad++;
          $display("FAIL sb_commit got ret=%h a=%h b=%h z=%b exp ret=%h a=%h b=%h z=%b",
                   bus.retired, dut.u_file.a_q, dut.u_file.b_q, bus.zero,
                   exp_ret, mod_a, mod_b, mod_z);
        end
      end
    end
  end

  task automatic slot(input logic [7:0] d, input logic [2:0] c, input logic v,
                      input logic st, input logic fl);
    bus.data_to_wb       = d;
    bus.control_acum_mem = c;
    bus.valid_mem        = v;
    bus.stall            = st;
    bus.flush            = fl;
  endtask

  task automatic idle();
    slot(8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    if (bus.valid_mem && !bus.stall && !bus.flush && bus.control_acum_mem[2] &&
        bus.control_acum_mem[1:0] != 2'b11)
      sb.push_back('{bus.control_acum_mem[1:0], bus.data_to_wb});
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_ret = '0;
    mod_a   = '0;
    mod_b   = '0;
    mod_z   = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    #12;
    total++; if (bus.acum_a !== 8'h00) begin bad++; $display("FAIL rst_acum_a got=%h exp=00", bus.acum_a); end
    total++; if (bus.acum_b !== 8'h00) begin bad++; $display("FAIL rst_acum_b got=%h exp=00", bus.acum_b); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL rst_zero got=%b exp=1", bus.zero); end
    total++; if (bus.wb_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.wb_busy); end
    total++; if (bus.retired !== 16'h0) begin bad++; $display("FAIL rst_retired got=%h exp=0000", bus.retired); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    slot(8'h3C, 3'b100, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.acum_a !== 8'h3C) begin bad++; $display("FAIL basic_bypass got=%h exp=3c", bus.acum_a); end
    total++; if (bus.wb_busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", bus.wb_busy); end
    total++; if (dut.u_file.a_q !== 8'h00) begin bad++; $display("FAIL basic_early_a got=%h exp=00", dut.u_file.a_q); end
    idle();
    step();
    total++; if (dut.u_file.a_q !== 8'h3C) begin bad++; $display("FAIL basic_stored_a got=%h exp=3c", dut.u_file.a_q); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL basic_zero got=%b exp=0", bus.zero); end
    total++; if (bus.retired !== 16'd1) begin bad++; $display("FAIL basic_retired got=%0d exp=1", bus.retired); end
    total++; if (bus.wb_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_clr got=%b exp=0", bus.wb_busy); end
  endtask

  task automatic test_back_to_back();
    slot(8'h11, 3'b101, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.acum_b !== 8'h11) begin bad++; $display("FAIL b2b_first got=%h exp=11", bus.acum_b); end
    slot(8'h22, 3'b101, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.acum_b !== 8'h22) begin bad++; $display("FAIL b2b_second got=%h exp=22", bus.acum_b); end
    total++; if (dut.u_file.b_q !== 8'h11) begin bad++; $display("FAIL b2b_mid_b got=%h exp=11", dut.u_file.b_q); end
    idle();
    step();
    total++; if (dut.u_file.b_q !== 8'h22) begin bad++; $display("FAIL b2b_final_b got=%h exp=22", dut.u_file.b_q); end
    total++; if (bus.retired !== 16'd3) begin bad++; $display("FAIL b2b_retired got=%0d exp=3", bus.retired); end
  endtask

  task automatic test_ab_and_reserved();
    slot(8'h00, 3'b110, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.acum_a !== 8'h00 || bus.acum_b !== 8'h00) begin bad++; $display("FAIL ab_bypass got a=%h b=%h exp 00/00", bus.acum_a, bus.acum_b); end
    idle();
    step();
    total++; if (dut.u_file.a_q !== 8'h00 || dut.u_file.b_q !== 8'h00) begin bad++; $display("FAIL ab_stored got a=%h b=%h exp 00/00", dut.u_file.a_q, dut.u_file.b_q); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL ab_zero got=%b exp=1", bus.zero); end
    total++; if (bus.retired !== 16'd4) begin bad++; $display("FAIL ab_retired got=%0d exp=4", bus.retired); end
    slot(8'h5A, 3'b111, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.wb_busy !== 1'b0) begin bad++; $display("FAIL rsvd_busy got=%b exp=0", bus.wb_busy); end
    total++; if (bus.acum_a !== 8'h00 || bus.acum_b !== 8'h00) begin bad++; $display("FAIL rsvd_bypass got a=%h b=%h exp 00/00", bus.acum_a, bus.acum_b); end
    idle();
    step();
    total++; if (bus.retired !== 16'd4 || bus.zero !== 1'b1) begin bad++; $display("FAIL rsvd_state got ret=%0d z=%b exp 4/1", bus.retired, bus.zero); end
    total++; if (dut.u_file.a_q !== 8'h00 || dut.u_file.b_q !== 8'h00) begin bad++; $display("FAIL rsvd_stored got a=%h b=%h exp 00/00", dut.u_file.a_q, dut.u_file.b_q); end
  endtask

  task automatic test_stall();
    slot(8'h55, 3'b100, 1'b1, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      slot(8'h66, 3'b100, 1'b1, 1'b1, 1'b0);
      step();
      total++; if (dut.u_file.a_q !== 8'h00 || bus.acum_a !== 8'h55 || bus.retired !== 16'd4) begin
        bad++; $display("FAIL stall_hold%0d got a=%h byp=%h ret=%0d exp 00/55/4", i, dut.u_file.a_q, bus.acum_a, bus.retired);
      end
    end
    idle();
    step();
    total++; if (dut.u_file.a_q !== 8'h55 || bus.retired !== 16'd5) begin bad++; $display("FAIL stall_release got a=%h ret=%0d exp 55/5", dut.u_file.a_q, bus.retired); end
  endtask

  task automatic test_flush();
    slot(8'h12, 3'b100, 1'b1, 1'b0, 1'b0);
    step();
    slot(8'h77, 3'b100, 1'b1, 1'b0, 1'b1);
    step();
    total++; if (bus.wb_busy !== 1'b0 || bus.acum_a !== 8'h12) begin bad++; $display("FAIL flush_squash got busy=%b byp=%h exp 0/12", bus.wb_busy, bus.acum_a); end
    total++; if (dut.u_file.a_q !== 8'h12 || bus.retired !== 16'd6) begin bad++; $display("FAIL flush_pending_commit got a=%h ret=%0d exp 12/6", dut.u_file.a_q, bus.retired); end
    idle();
    step();
    total++; if (dut.u_file.a_q !== 8'h12 || bus.retired !== 16'd6) begin bad++; $display("FAIL flush_never got a=%h ret=%0d exp 12/6", dut.u_file.a_q, bus.retired); end
    slot(8'h88, 3'b101, 1'b1, 1'b0, 1'b0);
    step();
    slot(8'h44, 3'b100, 1'b1, 1'b1, 1'b1);
    step();
    total++; if (bus.wb_busy !== 1'b1 || bus.acum_b !== 8'h88) begin bad++; $display("FAIL stflush_hold got busy=%b byp=%h exp 1/88", bus.wb_busy, bus.acum_b); end
    total++; if (dut.u_file.b_q !== 8'h00 || bus.retired !== 16'd6) begin bad++; $display("FAIL stflush_nocommit got b=%h ret=%0d exp 00/6", dut.u_file.b_q, bus.retired); end
    idle();
    step();
    total++; if (dut.u_file.b_q !== 8'h88 || bus.retired !== 16'd7) begin bad++; $display("FAIL stflush_commit got b=%h ret=%0d exp 88/7", dut.u_file.b_q, bus.retired); end
    total++; if (bus.acum_a !== 8'h12) begin bad++; $display("FAIL stflush_nocapture got=%h exp=12", bus.acum_a); end
  endtask

  task automatic test_reset_mid();
    slot(8'h99, 3'b101, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.acum_b !== 8'h99) begin bad++; $display("FAIL rmid_bypass got=%h exp=99", bus.acum_b); end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.acum_b !== 8'h00 || dut.u_file.b_q !== 8'h00) begin bad++; $display("FAIL rmid_b got byp=%h b=%h exp 00/00", bus.acum_b, dut.u_file.b_q); end
    total++; if (bus.retired !== 16'd0 || bus.zero !== 1'b1 || bus.wb_busy !== 1'b0) begin
      bad++; $display("FAIL rmid_state got ret=%0d z=%b busy=%b exp 0/1/0", bus.retired, bus.zero, bus.wb_busy);
    end
    #2;
    rst_n = 1'b1;
    idle();
    step();
    total++; if (dut.u_file.b_q !== 8'h00 || bus.retired !== 16'd0) begin bad++; $display("FAIL rmid_discard got b=%h ret=%0d exp 00/0", dut.u_file.b_q, bus.retired); end
  endtask

  task automatic test_wrap();
    logic [15:0] n;
    for (int i = 0; i < 65535; i++) begin
      n = 16'(i);
      slot(n[7:0], 3'b101, 1'b1, 1'b0, 1'b0);
      step();
    end
    idle();
    step();
    total++; if (bus.retired !== 16'hFFFF || dut.u_file.b_q !== 8'hFE) begin bad++; $display("FAIL wrap_preset got ret=%h b=%h exp ffff/fe", bus.retired, dut.u_file.b_q); end
    slot(8'h03, 3'b100, 1'b1, 1'b0, 1'b0);
    step();
    idle();
    step();
    total++; if (bus.retired !== 16'h0000 || dut.u_file.a_q !== 8'h03) begin bad++; $display("FAIL wrap_zero got ret=%h a=%h exp 0000/03", bus.retired, dut.u_file.a_q); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ab_and_reserved();
    test_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
